// File: rtl/bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// bcd_countdown_timer: loadable mm:ss BCD countdown with 1 s prescaler. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bcd_countdown_timer #(
  parameter int TICK_DIV = 100_000_000,
  parameter int PS_W     = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  localparam logic [PS_W-1:0] TICK_LAST = PS_W'(TICK_DIV - 1);

  state_t          state, state_next;
  logic [7:0]      min_q, min_next, sec_q, sec_next;
  logic [PS_W-1:0] ps, ps_next;
  logic            done_q, done_next, err_q, err_next;
  logic [7:0]      dec_min, dec_sec;
  logic            load_ok, value_zero;

  assign load_ok    = (load_min[7:4] <= 4'd9) && (load_min[3:0] <= 4'd9) &&
                      (load_sec[7:4] <= 4'd5) && (load_sec[3:0] <= 4'd9);
  assign value_zero = (min_q == 8'h00) && (sec_q == 8'h00);

  // One-second BCD decrement; only evaluated while RUN, where value is never 00:00.
  always_comb begin
    dec_min = min_q;
    dec_sec = sec_q;
    if (sec_q[3:0] != 4'd0) begin
      dec_sec = {sec_q[7:4], sec_q[3:0] - 4'd1};
    end else if (sec_q[7:4] != 4'd0) begin
      dec_sec = {sec_q[7:4] - 4'd1, 4'd9};
    end else begin
      dec_sec = 8'h59;
      if (min_q[3:0] != 4'd0) begin
        dec_min = {min_q[7:4], min_q[3:0] - 4'd1};
      end else if (min_q[7:4] != 4'd0) begin
        dec_min = {min_q[7:4] - 4'd1, 4'd9};
      end
    end
  end

  always_comb begin
    state_next = state;
    min_next   = min_q;
    sec_next   = sec_q;
    ps_next    = ps;
    done_next  = 1'b0;
    err_next   = 1'b0;
    if (clr) begin
      state_next = IDLE;
      min_next   = 8'h00;
      sec_next   = 8'h00;
      ps_next    = '0;
    end else if (load) begin
      // A rejected load freezes everything for the cycle, including the prescaler.
      if (load_ok) begin
        state_next = IDLE;
        min_next   = load_min;
        sec_next   = load_sec;
        ps_next    = '0;
      end else begin
        err_next = 1'b1;
      end
    end else begin
      case (state)
        IDLE: begin
          if (start && !pause && !value_zero) begin
            state_next = RUN;
            ps_next    = '0;
          end
        end
        RUN: begin
          if (pause) begin
            state_next = PAUSED;
          end else if (ps == TICK_LAST) begin
            ps_next  = '0;
            min_next = dec_min;
            sec_next = dec_sec;
            if ((dec_min == 8'h00) && (dec_sec == 8'h00)) begin
              state_next = EXPIRED;
              done_next  = 1'b1;
            end
          end else begin
            ps_next = ps + PS_W'(1);
          end
        end
        PAUSED: begin
          if (start && !pause) begin
            state_next = RUN;
          end
        end
        EXPIRED: begin
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      min_q  <= 8'h00;
      sec_q  <= 8'h00;
      ps     <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_next;
      min_q  <= min_next;
      sec_q  <= sec_next;
      ps     <= ps_next;
      done_q <= done_next;
      err_q  <= err_next;
    end
  end

  assign min_bcd = min_q;
  assign sec_bcd = sec_q;
  assign running = (state == RUN);
  assign expired = (state == EXPIRED);
  assign done    = done_q;
  assign err     = err_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_bcd_countdown_timer: directed bench for bcd_countdown_timer, TICK_DIV=4. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_bcd_countdown_timer;

  logic       clk;
  logic       rst, clr, load, start, pause;
  logic [7:0] load_min, load_sec;
  logic [7:0] min_bcd, sec_bcd;
  logic       running, expired, done, err;

  int total  = 0;
  int passed = 0;

  bcd_countdown_timer #(.TICK_DIV(4), .PS_W(3)) dut (
    .clk(clk), .rst(rst), .clr(clr), .load(load),
    .load_min(load_min), .load_sec(load_sec),
    .start(start), .pause(pause),
    .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .running(running), .expired(expired), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] s);
    load = 1'b1; load_min = m; load_sec = s;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; load = 1'b0; start = 1'b0; pause = 1'b0;
    load_min = 8'h00; load_sec = 8'h00;
    step(); step();
    rst = 1'b0;
    chk("rst_min", min_bcd, 8'h00);
    chk("rst_sec", sec_bcd, 8'h00);
    chk("rst_run", {7'd0, running}, 8'd0);
    chk("rst_exp", {7'd0, expired}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_err", {7'd0, err}, 8'd0);

    // Full countdown 00:03 -> 00:00
    do_load(8'h00, 8'h03);
    chk("t1_load", sec_bcd, 8'h03);
    do_start();
    chk("t1_running", {7'd0, running}, 8'd1);
    repeat (3) step();
    chk("t1_pre_tick", sec_bcd, 8'h03);
    step();
    chk("t1_tick1", sec_bcd, 8'h02);
    repeat (4) step();
    chk("t1_tick2", sec_bcd, 8'h01);
    repeat (3) step();
    chk("t1_nodone_early", {7'd0, done}, 8'd0);
    step();
    chk("t1_zero", sec_bcd, 8'h00);
    chk("t1_done", {7'd0, done}, 8'd1);
    chk("t1_expired", {7'd0, expired}, 8'd1);
    chk("t1_not_running", {7'd0, running}, 8'd0);
    step();
    chk("t1_done_one_cycle", {7'd0, done}, 8'd0);
    chk("t1_expired_held", {7'd0, expired}, 8'd1);

    // Start ignored while expired, then valid load recovers
    do_start();
    chk("t6_exp_start", {7'd0, expired}, 8'd1);
    chk("t6_exp_norun", {7'd0, running}, 8'd0);
    do_load(8'h02, 8'h30);
    chk("t6_exp_clear", {7'd0, expired}, 8'd0);
    chk("t6_load_min", min_bcd, 8'h02);
    do_start();
    repeat (4) step();
    chk("t6_min", min_bcd, 8'h02);
    chk("t6_sec", sec_bcd, 8'h29);

    // Borrow chains
    do_load(8'h10, 8'h00);
    chk("t2_load_idle", {7'd0, running}, 8'd0);
    do_start(); repeat (4) step();
    chk("t2a_min", min_bcd, 8'h09);
    chk("t2a_sec", sec_bcd, 8'h59);
    do_load(8'h01, 8'h00);
    do_start(); repeat (4) step();
    chk("t2b_min", min_bcd, 8'h00);
    chk("t2b_sec", sec_bcd, 8'h59);
    do_load(8'h00, 8'h10);
    do_start(); repeat (4) step();
    chk("t2c_sec", sec_bcd, 8'h09);
    do_load(8'h99, 8'h59);
    chk("t2d_load_max", min_bcd, 8'h99);
    do_start(); repeat (4) step();
    chk("t2d_sec", sec_bcd, 8'h58);

    // Pause and resume with prescaler held at 2
    do_load(8'h00, 8'h05);
    do_start();
    step(); step();
    pause = 1'b1; step(); pause = 1'b0;
    chk("t3_paused", {7'd0, running}, 8'd0);
    repeat (20) step();
    chk("t3_frozen", sec_bcd, 8'h05);
    do_start();
    chk("t3_resumed", {7'd0, running}, 8'd1);
    step();
    chk("t3_run1", sec_bcd, 8'h05);
    step();
    chk("t3_run2", sec_bcd, 8'h04);
    repeat (3) step();
    pause = 1'b1; step(); pause = 1'b0;
    chk("t3_pause_on_tick", sec_bcd, 8'h04);
    do_start(); step();
    chk("t3_held_tick", sec_bcd, 8'h03);

    // clr and load together mid-RUN
    clr = 1'b1; load = 1'b1; load_min = 8'h00; load_sec = 8'h45;
    step();
    clr = 1'b0; load = 1'b0;
    chk("t5_clr_sec", sec_bcd, 8'h00);
    chk("t5_clr_run", {7'd0, running}, 8'd0);
    chk("t5_clr_done", {7'd0, done}, 8'd0);

    // Rejected loads
    do_load(8'h00, 8'h12);
    do_load(8'h00, 8'h7A);
    chk("t4_err_digit", {7'd0, err}, 8'd1);
    chk("t4_keep_val", sec_bcd, 8'h12);
    step();
    chk("t4_err_pulse", {7'd0, err}, 8'd0);
    do_load(8'h00, 8'h60);
    chk("t4_err_tens", {7'd0, err}, 8'd1);
    chk("t4_keep_val2", sec_bcd, 8'h12);
    do_load(8'hA0, 8'h00);
    chk("t4_err_min", {7'd0, err}, 8'd1);

    // start at 00:00 in IDLE is ignored
    clr = 1'b1; step(); clr = 1'b0;
    do_start();
    chk("t4_zero_start", {7'd0, running}, 8'd0);
    step();
    chk("t4_zero_nodone", {7'd0, done}, 8'd0);

    // start+pause together in IDLE
    do_load(8'h00, 8'h12);
    start = 1'b1; pause = 1'b1; step(); start = 1'b0; pause = 1'b0;
    chk("t5_sp_idle", {7'd0, running}, 8'd0);

    // rst mid-RUN
    do_start(); step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("t5_rst_sec", sec_bcd, 8'h00);
    chk("t5_rst_run", {7'd0, running}, 8'd0);
    chk("t5_rst_done", {7'd0, done}, 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Loadable mm:ss countdown timer driven by an internal 1 s prescaler. It consumes the same 100 MHz one-second time base our up-counters produce, but counts down in BCD, with minutes 00-99 and seconds 00-59. It feeds the 7-segment display path and raises a one-cycle done pulse plus a sticky expired flag at 00:00. Control comes from debounced, single-cycle button pulses.

Parameters:
TICK_DIV, 100_000_000, clk cycles per decrement (1 s at 100 MHz); must be ≥2
PS_W, 27, prescaler width; must satisfy 2^PS_W ≥ TICK_DIV

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
clr  in  1  sync clear to 00:00 / IDLE
load  in  1  capture load_min/load_sec
load_min  in  8  BCD minutes {tens,units}
load_sec  in  8  BCD seconds {tens,units}
start  in  1  start/resume
pause  in  1  pause
min_bcd  out  8  current minutes, BCD
sec_bcd  out  8  current seconds, BCD
running  out  1  state==RUN
expired  out  1  state==EXPIRED
done  out  1  one-cycle pulse on reaching 00:00
err  out  1  one-cycle pulse on rejected load

Behaviour:
- All outputs registered or decoded from registered state.
- Reset: state IDLE, value 00:00, prescaler 0, done=err=0, running=expired=0.
- Control priority, highest first: rst > clr > load > pause > start.
- States: IDLE, RUN, PAUSED, EXPIRED.
- clr, any state: go to IDLE, value 00:00, prescaler 0.
- Load validity: every digit ≤9 and sec tens ≤5.
  - Valid load, any state: go to IDLE, value := inputs, prescaler 0.
  - Invalid load: err=1 next cycle; state, value and prescaler unchanged.
- IDLE:
  - start with value ≠00:00 → RUN, prescaler 0.
  - start at 00:00 is ignored (no done).
- RUN:
  - pause → PAUSED; prescaler held; no decrement that cycle, even if a tick was due.
  - tick = RUN & !pause & prescaler==TICK_DIV-1. Otherwise the prescaler increments each RUN cycle.
  - On tick: prescaler := 0 and value decrements by 1 s, giving TICK_DIV cycles per decrement.
- Decrement rules:
  - sec units 0 → 9 with borrow from sec tens.
  - sec 00 → 59 with borrow from minutes.
  - min units 0 → 9 with borrow from min tens.
- If the decremented value is 00:00: same edge → EXPIRED, done=1 for exactly that following cycle, and min_bcd/sec_bcd read 00:00 in that cycle.
- PAUSED:
  - start → RUN; prescaler resumes from its held value.
  - Value is frozen; pause is a no-op.
- EXPIRED:
  - expired held high; value stays 00:00; start and pause ignored.
  - Exit only via clr, valid load, or rst.
- start and pause together: pause wins.
  - IDLE stays IDLE; RUN → PAUSED; PAUSED stays PAUSED.
- No wrap below 00:00; the counter never underflows.
- 99:59 is a legal load.
- Reset or clr mid-RUN aborts with no done pulse.

Test Plan:
1. TICK_DIV=4. Load 00:03, start → 00:02 four cycles after entering RUN, 00:01 at +8, 00:00 at +12. done high exactly 1 cycle, expired=1 and running=0 from then on.
2. TICK_DIV=4. Load 10:00, start, one tick → 09:59. Load 01:00, one tick → 00:59. Load 00:10, one tick → 00:09.
3. TICK_DIV=4. Load 00:05, start, pause when prescaler=2. Hold 20 cycles: value stays 00:05. Start → 00:04 on the 2nd RUN cycle. Pause asserted in the tick cycle → no decrement.
4. Load 00:7A → err pulse, value unchanged. Load 00:60 → err. In IDLE at 00:00, start → remains IDLE, done=0.
5. Mid-RUN clr and load same cycle → 00:00 IDLE. Mid-RUN rst → all outputs reset. start+pause together in IDLE → stays IDLE.
6. After expiry, start ignored and expired stays 1. Valid load 02:30 → IDLE, expired=0. Start → counts 02:29 after TICK_DIV cycles.
